// File: rtl/gas_detector_sensor_if.sv
// gas_detector_sensor_if
//   Serial sensor link bundle for the gas detector front-end.
//   din  : serial sensor bit, one per clk rising edge (sensor -> front-end)
//   dout : last valid 3-bit gas level (front-end -> alarm/display)
//   master : sensor side / testbench (drives din, observes dout)
//   slave  : gas_detector_sensor (samples din, drives dout)
interface gas_detector_sensor_if;
    logic       din;
    logic [2:0] dout;

    modport master (output din, input dout);
    modport slave  (input din, output dout);
endinterface

// File: rtl/gas_detector_sensor.sv
// gas_detector_sensor
//   Serial frame receiver for the gas sensor. Frame, in sampling order:
//   start(1), d2, d1, d0, [even parity], stop(1). Line idles at 0.
//   A frame with a good stop bit (and good parity when enabled) updates
//   dout; any other frame is dropped and dout keeps the last good level.
// Ports:
//   clk  : system clock, rising-edge sampling
//   arst : asynchronous active-low reset
//   bus  : gas_detector_sensor_if.slave (din in, dout out)
// Build option:
//   GAS_PARITY_EN : insert an even-parity bit between d0 and stop.
module gas_detector_sensor (
    input  logic                  clk,
    input  logic                  arst,
    gas_detector_sensor_if.slave  bus
);

`ifdef GAS_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_D2   = 3'd1,
        S_D1   = 3'd2,
        S_D0   = 3'd3,
        S_PAR  = 3'd4,
        S_STOP = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_D2   = 3'd1,
        S_D1   = 3'd2,
        S_D0   = 3'd3,
        S_STOP = 3'd5
    } state_t;
`endif

    state_t     state, state_nxt;
    logic [2:0] shreg;
    logic [2:0] level;
    logic       frame_ok;
`ifdef GAS_PARITY_EN
    logic       par_acc;
`endif

    // State register
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state: STOP always returns to IDLE, so the stop bit can
    // never double as the next start bit.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.din) state_nxt = S_D2;
            S_D2:    state_nxt = S_D1;
            S_D1:    state_nxt = S_D0;
`ifdef GAS_PARITY_EN
            S_D0:    state_nxt = S_PAR;
            S_PAR:   state_nxt = S_STOP;
`else
            S_D0:    state_nxt = S_STOP;
`endif
            S_STOP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Accept condition evaluated while sampling the stop bit
    always_comb begin
`ifdef GAS_PARITY_EN
        // par_acc already holds d2^d1^d0^parity; even parity means 0
        frame_ok = bus.din && !par_acc;
`else
        frame_ok = bus.din;
`endif
    end

    // Data path: shift register, parity accumulator, output level
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            shreg <= 3'b000;
            level <= 3'b000;
`ifdef GAS_PARITY_EN
            par_acc <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
`ifdef GAS_PARITY_EN
                    par_acc <= 1'b0;
`endif
                end
                S_D2, S_D1, S_D0: begin
                    shreg <= {shreg[1:0], bus.din};
`ifdef GAS_PARITY_EN
                    par_acc <= par_acc ^ bus.din;
`endif
                end
`ifdef GAS_PARITY_EN
                S_PAR: par_acc <= par_acc ^ bus.din;
`endif
                S_STOP: if (frame_ok) level <= shreg;
                default: ;
            endcase
        end
    end

    assign bus.dout = level;

endmodule

// File: tb/tb_gas_detector_sensor.sv
module tb_gas_detector_sensor;
    logic clk;
    logic arst;
    int   n_cmp;
    int   n_mis;

    gas_detector_sensor_if bus ();

    gas_detector_sensor dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive n bits of v MSB first, one per rising edge; return #1 after last edge.
    task automatic send(input logic [7:0] v, input int n);
        logic [7:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--) begin
            bus.din = t[i];
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        arst = 1'b0;
        bus.din = 1'b0;

        // Reset
        @(posedge clk); #1;
        chk("reset_dout", bus.dout, 3'b000);
        arst = 1'b1;
        send(8'b00, 2);
        chk("idle_after_reset", bus.dout, 3'b000);

        // Valid frame 1,0,1,0,1 -> 010; no update before stop edge
        send(8'b1010, 4);
        chk("latency_hold", bus.dout, 3'b000);
        send(8'b1, 1);
        chk("frame_010", bus.dout, 3'b010);

        // 0,0,1,0,0,1,1 -> 001
        send(8'b001001, 6);
        chk("hold_before_stop", bus.dout, 3'b010);
        send(8'b1, 1);
        chk("frame_001", bus.dout, 3'b001);

        // Framing error 1,1,1,0,0 -> hold 001
        send(8'b11100, 5);
        chk("framing_err_hold", bus.dout, 3'b001);

        // 1,1,1,1,1 -> 111
        send(8'b1111, 4);
        chk("hold_pre_111", bus.dout, 3'b001);
        send(8'b1, 1);
        chk("frame_111", bus.dout, 3'b111);

        // Back-to-back frames
        send(8'b10111, 5);
        chk("b2b_first_011", bus.dout, 3'b011);
        send(8'b11001, 5);
        chk("b2b_second_100", bus.dout, 3'b100);

        // Reset mid-frame
        send(8'b111, 3);
        chk("midframe_pre_reset", bus.dout, 3'b100);
        arst = 1'b0;
        #2;
        chk("async_reset_dout", bus.dout, 3'b000);
        bus.din = 1'b1;
        @(posedge clk); #1;
        chk("reset_held_din1", bus.dout, 3'b000);
        arst = 1'b1;
        send(8'b11011, 5);
        chk("after_reset_101", bus.dout, 3'b101);

        // Value zero is a valid level
        send(8'b10001, 5);
        chk("frame_000", bus.dout, 3'b000);

`ifdef GAS_PARITY_EN
        send(8'b111001, 6);
        chk("par_good_110", bus.dout, 3'b110);
        send(8'b111011, 6);
        chk("par_bad_hold", bus.dout, 3'b110);
        send(8'b100111, 6);
        chk("par_good_001", bus.dout, 3'b001);
`else
        // Stop bit not reused as start: 1,0,1,1,1 then 0,1,1,0,1,1
        send(8'b10111, 5);
        chk("frame_011", bus.dout, 3'b011);
        send(8'b011011, 6);
        chk("frame_101_after_gap", bus.dout, 3'b101);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/gas_detector_sensor.md
# gas_detector_sensor

Serial front-end for the gas detector. It receives fixed-format frames from the gas sensor on a single-bit line, one bit per clock. Each valid frame carries a 3-bit gas concentration level, which is registered and held on `dout` for the downstream alarm and display logic. Invalid frames are discarded, and `dout` keeps the last good level.

## Interface
- No parameters.
- `clk`  input  1  system clock; all sampling on rising edge.
- `arst`  input  1  asynchronous, active-low reset.
- `din`  input  1  serial sensor data, one bit sampled per rising edge of `clk`.
- `dout`  output  3  last valid gas level received; registered.

## Operation
- Frame format, in sampling order:
  - start bit = 1
  - data bits d2, d1, d0 (MSB first)
  - [parity bit, only when `GAS_PARITY_EN` is defined]
  - stop bit = 1
- The line idles at 0.
- FSM states:
  - IDLE, START_WAIT: stay while `din`=0. Go to D2 on `din`=1.
  - D2, D1, D0: shift `din` into a 3-bit shift register.
  - PAR: present only with `GAS_PARITY_EN`.
  - STOP: check the stop bit, then go to IDLE.
- In STOP:
  - If `din`=1 and parity is OK (or parity is disabled): `dout` <= shifted data.
  - Otherwise (framing error or parity error): discard the frame, and `dout` holds its value.
  - In both cases, return to IDLE.
- IDLE is re-entered after STOP unconditionally. The stop bit is never reused as the next start bit.
- Data bits are taken verbatim, with no range check. All values 0..7 are valid.
- Reset (`arst`=0), asynchronous:
  - state = IDLE
  - shift register = 0
  - parity accumulator = 0
  - `dout` = 3'b000
- A reset mid-frame aborts the frame. Reception resumes with a fresh start bit after `arst` deasserts.
- `din` is assumed synchronous to `clk`. There is no internal synchronizer.

## Timing
- One bit per clock cycle. There is no oversampling.
- Without parity, a frame is 5 cycles: start, d2, d1, d0, stop.
- `dout` changes on the rising edge that samples a valid stop bit. The new value is visible immediately after that edge.
- Latency: `dout` updates 4 cycles after the edge that sampled the start bit.
- Back-to-back frames:
  - The earliest next start bit is sampled on the edge after the stop edge.
  - Minimum frame period is 5 cycles.
- `dout` is glitch-free. It is driven directly from a register and changes only on a valid frame or on reset.
- On the first rising edge after `arst` deasserts, `din` is evaluated as a potential start bit.

## Configuration
- `GAS_PARITY_EN` defined:
  - An even-parity bit is inserted between d0 and the stop bit. The frame becomes 6 cycles.
  - The frame is accepted only if d2^d1^d0^parity == 0.
  - On a parity mismatch, the frame is discarded and `dout` holds.
  - Latency becomes 5 cycles from the start-bit edge.
- `GAS_PARITY_EN` undefined:
  - No parity state exists.
  - Frames are 5 bits, and only the stop bit is checked.

## Test plan
- Reset: hold `arst`=0 for 1 cycle with `din`=0 -> `dout`=000 and the FSM is in IDLE. Release and keep `din`=0 for 2 cycles -> `dout` stays 000.
- Valid frame, parity off: `din` = 1,0,1,0,1 on successive edges -> `dout`=010 right after the 5th edge. Then 0,0,1,0,0,1,1 -> `dout`=001 right after the final edge.
- Framing error: `din` = 1,1,1,0,0 after `dout`=001 -> `dout` stays 001. A following frame 1,1,1,1,1 -> `dout`=111.
- Back-to-back frames: 1,0,1,1,1 immediately followed by 1,1,0,0,1 -> `dout`=011 after edge 5, then 100 after edge 10.
- Reset mid-frame: send 1,1,1, then pulse `arst`=0 -> `dout`=000 and the FSM returns to IDLE. Send 1,1,0,1,1 -> `dout`=101.
- Parity, with `GAS_PARITY_EN`: frame 1,1,1,0,0,1 -> `dout`=110. Frame 1,1,1,0,1,1 (bad parity) -> `dout` stays 110.
